// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Lookups hit combinationally in the same cycle. A miss starts a single-word
// refill through a level request / done-pulse handshake.
module icache #(
  parameter int INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] inst_addr_i,
  output logic        inst_enable_o,
  output logic [31:0] inst_data_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_done_i,
  input  logic [31:0] mem_data_i
);

  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_BITS-1:0] lookup_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill_en;
  logic                  req_next;
  logic [31:0]           addr_next;

  // The byte offset does not take part in the lookup.
  logic unused_offset;
  assign unused_offset = ^inst_addr_i[1:0];

  assign lookup_index = inst_addr_i[INDEX_BITS+1:2];
  assign lookup_tag   = inst_addr_i[31:INDEX_BITS+2];
  assign fill_index   = mem_addr_o[INDEX_BITS+1:2];
  assign fill_tag     = mem_addr_o[31:INDEX_BITS+2];

  // Hit path is independent of the refill state and of rdy; it is masked
  // during reset so IF never sees stale lines while valid bits are clearing.
  assign hit           = valid[lookup_index] && (tag_mem[lookup_index] == lookup_tag) && !rst;
  assign inst_enable_o = hit;
  assign inst_data_o   = hit ? data_mem[lookup_index] : 32'h0;

  // Next-state logic for the refill controller; nothing moves while rdy is low.
  always_comb begin
    state_next = state;
    req_next   = mem_req_o;
    addr_next  = mem_addr_o;
    fill_en    = 1'b0;
    if (rdy) begin
      case (state)
        IDLE: begin
          if (!hit) begin
            addr_next  = {inst_addr_i[31:2], 2'b00};
            req_next   = 1'b1;
            state_next = FETCH;
          end
        end
        FETCH: begin
          // The latched address is refilled even if IF has moved on.
          if (mem_done_i) begin
            fill_en    = 1'b1;
            req_next   = 1'b0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Control registers: FSM state, request handshake and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'h0;
      valid      <= '0;
    end else begin
      state      <= state_next;
      mem_req_o  <= req_next;
      mem_addr_o <= addr_next;
      if (fill_en) begin
        valid[fill_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; a reset-cycle done is discarded.
  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= mem_data_i;
    end
  end

endmodule
